// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined logic unit: op encodings, op width and FIFO depth.
// LOGIC_UNIT_REDUCE_EN (optional) adds the all-ones/parity flags elsewhere in this slice.
package logic_unit_pkg;

   localparam int OP_W     = 3;
   localparam int LU_DEPTH = 2;

   localparam logic [OP_W-1:0] OP_AND   = 3'd0;
   localparam logic [OP_W-1:0] OP_OR    = 3'd1;
   localparam logic [OP_W-1:0] OP_NAND  = 3'd2;
   localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// LOGIC_UNIT_REDUCE_EN adds out_all_ones and out_parity.
interface logic_unit_pipe_if #(parameter int WIDTH = 8);
   import logic_unit_pkg::*;

   // Both channels transfer on a cycle where valid & ready are high at the rising edge;
   // a producer holds valid and its payload steady until that transfer happens.
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic [OP_W-1:0]   in_op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_y;
   logic [OP_W-1:0]   out_op;
   logic              out_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
   logic              out_all_ones;
   logic              out_parity;
`endif

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_y, out_op, out_zero
`ifdef LOGIC_UNIT_REDUCE_EN
      , input out_all_ones, out_parity
`endif
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_y, out_op, out_zero
`ifdef LOGIC_UNIT_REDUCE_EN
      , output out_all_ones, out_parity
`endif
   );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational bitwise op datapath: (a, b, op) -> y plus result flags.
// LOGIC_UNIT_REDUCE_EN adds the all-ones and parity flags.
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y,
   output logic             zero
`ifdef LOGIC_UNIT_REDUCE_EN
   ,
   output logic             all_ones,
   output logic             parity
`endif
);

   always_comb begin
      y = a;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
         OP_NOTA:  y = ~a;
         OP_PASSA: y = a;
         default:  y = a;
      endcase
   end

   assign zero = (y == '0);
`ifdef LOGIC_UNIT_REDUCE_EN
   assign all_ones = &y;
   assign parity   = ^y;
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit: computes on accept, buffers results in a 2-entry skid FIFO.
// LOGIC_UNIT_REDUCE_EN stores and outputs all-ones/parity flags per entry.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   logic_unit_pipe_if.slave bus
);

   logic [WIDTH-1:0] core_y;
   logic             core_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
   logic             core_all_ones;
   logic             core_parity;
`endif

   logic_unit_core #(.WIDTH(WIDTH)) u_core (
      .a        (bus.in_a),
      .b        (bus.in_b),
      .op       (bus.in_op),
      .y        (core_y),
      .zero     (core_zero)
`ifdef LOGIC_UNIT_REDUCE_EN
      ,
      .all_ones (core_all_ones),
      .parity   (core_parity)
`endif
   );

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] y_mem_q    [LU_DEPTH];
   logic [WIDTH-1:0] y_mem_d    [LU_DEPTH];
   logic [OP_W-1:0]  op_mem_q   [LU_DEPTH];
   logic [OP_W-1:0]  op_mem_d   [LU_DEPTH];
   logic             zero_mem_q [LU_DEPTH];
   logic             zero_mem_d [LU_DEPTH];
   // Last popped entry, shown while empty so the outputs do not expose stale slots.
   logic [WIDTH-1:0] last_y_q, last_y_d;
   logic [OP_W-1:0]  last_op_q, last_op_d;
   logic             last_zero_q, last_zero_d;
`ifdef LOGIC_UNIT_REDUCE_EN
   logic             ao_mem_q  [LU_DEPTH];
   logic             ao_mem_d  [LU_DEPTH];
   logic             par_mem_q [LU_DEPTH];
   logic             par_mem_d [LU_DEPTH];
   logic             last_ao_q, last_ao_d;
   logic             last_par_q, last_par_d;
`endif

   logic push, pop, not_empty;

   assign not_empty    = (count_q != 2'd0);
   assign bus.in_ready = (count_q != 2'(LU_DEPTH));
   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = not_empty & bus.out_ready;

   always_comb begin
      count_d     = count_q + 2'(push) - 2'(pop);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      y_mem_d     = y_mem_q;
      op_mem_d    = op_mem_q;
      zero_mem_d  = zero_mem_q;
      last_y_d    = last_y_q;
      last_op_d   = last_op_q;
      last_zero_d = last_zero_q;
`ifdef LOGIC_UNIT_REDUCE_EN
      ao_mem_d    = ao_mem_q;
      par_mem_d   = par_mem_q;
      last_ao_d   = last_ao_q;
      last_par_d  = last_par_q;
`endif
      if (push) begin
         y_mem_d[wr_ptr_q]    = core_y;
         op_mem_d[wr_ptr_q]   = bus.in_op;
         zero_mem_d[wr_ptr_q] = core_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
         ao_mem_d[wr_ptr_q]   = core_all_ones;
         par_mem_d[wr_ptr_q]  = core_parity;
`endif
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         last_y_d    = y_mem_q[rd_ptr_q];
         last_op_d   = op_mem_q[rd_ptr_q];
         last_zero_d = zero_mem_q[rd_ptr_q];
`ifdef LOGIC_UNIT_REDUCE_EN
         last_ao_d   = ao_mem_q[rd_ptr_q];
         last_par_d  = par_mem_q[rd_ptr_q];
`endif
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= 2'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         y_mem_q     <= '{default: '0};
         op_mem_q    <= '{default: '0};
         zero_mem_q  <= '{default: 1'b1};
         last_y_q    <= '0;
         last_op_q   <= '0;
         last_zero_q <= 1'b1;
`ifdef LOGIC_UNIT_REDUCE_EN
         ao_mem_q    <= '{default: 1'b0};
         par_mem_q   <= '{default: 1'b0};
         last_ao_q   <= 1'b0;
         last_par_q  <= 1'b0;
`endif
      end else begin
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         y_mem_q     <= y_mem_d;
         op_mem_q    <= op_mem_d;
         zero_mem_q  <= zero_mem_d;
         last_y_q    <= last_y_d;
         last_op_q   <= last_op_d;
         last_zero_q <= last_zero_d;
`ifdef LOGIC_UNIT_REDUCE_EN
         ao_mem_q    <= ao_mem_d;
         par_mem_q   <= par_mem_d;
         last_ao_q   <= last_ao_d;
         last_par_q  <= last_par_d;
`endif
      end
   end

   assign bus.out_valid    = not_empty;
   assign bus.out_y        = not_empty ? y_mem_q[rd_ptr_q]    : last_y_q;
   assign bus.out_op       = not_empty ? op_mem_q[rd_ptr_q]   : last_op_q;
   assign bus.out_zero     = not_empty ? zero_mem_q[rd_ptr_q] : last_zero_q;
`ifdef LOGIC_UNIT_REDUCE_EN
   assign bus.out_all_ones = not_empty ? ao_mem_q[rd_ptr_q]   : last_ao_q;
   assign bus.out_parity   = not_empty ? par_mem_q[rd_ptr_q]  : last_par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8): directed steps plus random traffic
// scored against a truth-table model and an expected-result queue.
module tb_logic_unit_pipe;
   import logic_unit_pkg::*;

   localparam int WIDTH = 8;
   localparam int EW    = OP_W + WIDTH;

   logic clk;
   logic rst;

   logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

   logic_unit_pipe #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_e;
   int            n_checks;
   int            n_err;
   int            pop_count;

   // Per-bit truth table indexed by {a_bit, b_bit}.
   function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, b, input logic [OP_W-1:0] op);
      logic [3:0]       tt;
      logic [WIDTH-1:0] y;
      case (op)
         3'd0: tt = 4'b1000;
         3'd1: tt = 4'b1110;
         3'd2: tt = 4'b0111;
         3'd3: tt = 4'b0001;
         3'd4: tt = 4'b0110;
         3'd5: tt = 4'b1001;
         3'd6: tt = 4'b0011;
         default: tt = 4'b1100;
      endcase
      for (int i = 0; i < WIDTH; i++) y[i] = tt[{a[i], b[i]}];
      return {op, y};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_entry(input string tag, input logic [EW-1:0] e);
      logic [WIDTH-1:0] y;
      y = e[WIDTH-1:0];
      check({tag, "_y"}, 32'(bus.out_y), 32'(y));
      check({tag, "_op"}, 32'(bus.out_op), 32'(e[EW-1:WIDTH]));
      check({tag, "_zero"}, 32'(bus.out_zero), 32'(y == '0));
`ifdef LOGIC_UNIT_REDUCE_EN
      check({tag, "_all_ones"}, 32'(bus.out_all_ones), 32'(&y));
      check({tag, "_parity"}, 32'(bus.out_parity), 32'(^y));
`endif
   endtask

   // One clock: check outputs against the model at negedge, advance the model, return #1 after posedge.
   task automatic cycle();
      bit do_pop, do_push;
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         last_e = '0;
      end else begin
         check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < LU_DEPTH));
         check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check_entry("head", exp_q[0]);
         else                   check_entry("hold", last_e);
         do_pop  = bus.out_ready && (exp_q.size() != 0);
         do_push = bus.in_valid && (exp_q.size() < LU_DEPTH);
         if (do_pop) begin
            last_e = exp_q.pop_front();
            pop_count++;
         end
         if (do_push) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, b, input logic [OP_W-1:0] op);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
   endtask

   // ---------------- directed + random sequence ----------------
   logic [WIDTH-1:0] sweep_tbl [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

   initial begin
      n_checks  = 0;
      n_err     = 0;
      pop_count = 0;
      last_e    = '0;
      rst = 1'b1;
      drive(1'b0, '0, '0, '0);
      bus.out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;

      // Reset state
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_y", 32'(bus.out_y), 32'd0);
      check("rst_out_op", 32'(bus.out_op), 32'd0);
      check("rst_out_zero", 32'(bus.out_zero), 32'd1);

      // Op sweep, one cycle latency
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'hF0, 8'hCC, 3'(i));
         cycle();
         check("sweep_valid", 32'(bus.out_valid), 32'd1);
         check("sweep_y", 32'(bus.out_y), 32'(sweep_tbl[i]));
      end
      drive(1'b0, '0, '0, '0);
      cycle();
      check("sweep_drained", 32'(bus.out_valid), 32'd0);

      // Backpressure
      bus.out_ready = 1'b0;
      pop_count = 0;
      drive(1'b1, 8'h12, 8'h34, OP_XOR);
      cycle();
      drive(1'b1, 8'h56, 8'h78, OP_OR);
      cycle();
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 8'h9A, 8'hBC, OP_NAND);
      cycle();
      cycle();
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      drive(1'b0, '0, '0, '0);
      cycle();
      cycle();
      check("bp_pop_count", 32'(pop_count), 32'd3);
      check("bp_empty", 32'(bus.out_valid), 32'd0);

      // Streaming
      pop_count = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), OP_W'($urandom_range(0, 7)));
         cycle();
      end
      drive(1'b0, '0, '0, '0);
      cycle();
      check("stream_pop_count", 32'(pop_count), 32'd16);

      // Zero flag
      drive(1'b1, 8'hAA, 8'h55, OP_AND);
      cycle();
      check("zero_and_y", 32'(bus.out_y), 32'h00);
      check("zero_and_flag", 32'(bus.out_zero), 32'd1);
      drive(1'b1, 8'hAA, 8'h55, OP_OR);
      cycle();
      check("zero_or_y", 32'(bus.out_y), 32'hFF);
      check("zero_or_flag", 32'(bus.out_zero), 32'd0);
      drive(1'b0, '0, '0, '0);
      cycle();

      // Reset mid-stall
      bus.out_ready = 1'b0;
      drive(1'b1, 8'h3C, 8'h0F, OP_OR);
      cycle();
      drive(1'b1, 8'h81, 8'h18, OP_XNOR);
      cycle();
      rst = 1'b1;
      drive(1'b1, 8'hFF, 8'h00, OP_PASSA);
      cycle();
      rst = 1'b0;
      drive(1'b0, '0, '0, '0);
      check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("mrst_out_y", 32'(bus.out_y), 32'd0);
      check("mrst_out_zero", 32'(bus.out_zero), 32'd1);
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      cycle();

`ifdef LOGIC_UNIT_REDUCE_EN
      drive(1'b1, 8'h07, 8'h00, OP_PASSA);
      cycle();
      check("red_pass_parity", 32'(bus.out_parity), 32'd1);
      check("red_pass_all_ones", 32'(bus.out_all_ones), 32'd0);
      drive(1'b1, 8'h07, 8'h00, OP_NOTA);
      cycle();
      check("red_nota_y", 32'(bus.out_y), 32'hF8);
      check("red_nota_parity", 32'(bus.out_parity), 32'd1);
      drive(1'b1, 8'hFF, 8'hFF, OP_AND);
      cycle();
      check("red_and_all_ones", 32'(bus.out_all_ones), 32'd1);
      drive(1'b0, '0, '0, '0);
      cycle();
`endif

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom), OP_W'($urandom_range(0, 7)));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drive(1'b0, '0, '0, '0);
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      check("final_empty", 32'(bus.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
